// File: rtl/mem_responder_pkg.sv
// Shared types for the CPU memory responder.
// State encoding, region code, request bundle and defaults.
package mem_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INT_ACC,
    S_INT_RD,
    S_EXT_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] REGION_INT = 3'b000;

  localparam int EXT_TIMEOUT_DEF = 255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        we;
    logic [26:0] addr;
    logic [31:0] data;
  } mem_req_t;

  function automatic logic is_int(
    input logic [26:0] a
  );
    return a[26:24] == REGION_INT;
  endfunction

endpackage

// File: rtl/mem_ext_timer.sv
// External bus wait counter; expired flags the last allowed cycle.
// Ports: clk, reset (async low), clear, enable, limit -> expired.
module mem_ext_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Counter holds k during the (k+1)th wait cycle.
  assign expired = (cnt == limit - 16'd1);

endmodule

// File: rtl/mem_responder.sv
// CPU memory request responder: internal block RAM or external bus.
// Ports: start/we/address/data -> q/busy; ram_* and ext_* side; bus_err.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          INT_ADDR_BITS = 14,
  parameter int          EXT_TIMEOUT   = EXT_TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA      = ERR_DATA_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     we,
  input  logic [26:0]              address,
  input  logic [31:0]              data,
  output logic [31:0]              q,
  output logic                     busy,
  output logic [INT_ADDR_BITS-1:0] ram_addr,
  output logic [31:0]              ram_d,
  output logic                     ram_we,
  input  logic [31:0]              ram_q,
  output logic                     ext_req,
  output logic                     ext_we,
  output logic [26:0]              ext_addr,
  output logic [31:0]              ext_wdata,
  input  logic                     ext_ack,
  input  logic [31:0]              ext_rdata,
  output logic                     bus_err
);

  localparam logic [15:0] TMO_LIMIT = 16'(EXT_TIMEOUT);

  state_t   state;
  state_t   state_nx;
  mem_req_t req;
  logic     tmo_exp;
  logic     in_ext;
  logic     tmo_hit;

  assign in_ext  = (state == S_EXT_WAIT);
  // A coincident ack wins over the timeout.
  assign tmo_hit = in_ext && !ext_ack && tmo_exp;

  mem_ext_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_ext),
    .enable  (in_ext && !ext_ack),
    .limit   (TMO_LIMIT),
    .expired (tmo_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = is_int(address) ? S_INT_ACC : S_EXT_WAIT;
        end
      end
      S_INT_ACC: begin
        state_nx = req.we ? S_DONE : S_INT_RD;
      end
      S_INT_RD: begin
        state_nx = S_DONE;
      end
      S_EXT_WAIT: begin
        if (ext_ack || tmo_exp) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req     <= '0;
      q       <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo_hit;
      if (state == S_IDLE && start) begin
        req <= '{we: we, addr: address, data: data};
      end
      if (state == S_INT_RD) begin
        q <= ram_q;
      end
      if (in_ext && ext_ack && !req.we) begin
        q <= ext_rdata;
      end
      if (tmo_hit && !req.we) begin
        q <= ERR_DATA;
      end
    end
  end

  // Upper internal index bits are dropped, so the region aliases.
  assign ram_addr  = req.addr[INT_ADDR_BITS-1:0];
  assign ram_d     = req.data;
  assign ram_we    = (state == S_INT_ACC) && req.we;

  assign ext_req   = in_ext;
  assign ext_we    = req.we;
  assign ext_addr  = req.addr;
  assign ext_wdata = req.data;

  // Gated by reset so it is low while reset is held.
  assign busy = reset && (
    (state == S_IDLE && start) ||
    state == S_INT_ACC ||
    state == S_INT_RD ||
    in_ext
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Directed scenarios plus randomized transactions vs a behavioural model.
module tb_mem_responder;

  localparam int TMO = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        we;
  logic [26:0] address;
  logic [31:0] data;
  logic [31:0] q;
  logic        busy;
  logic [13:0] ram_addr;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [31:0] ram_q;
  logic        ext_req;
  logic        ext_we;
  logic [26:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        bus_err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] q_exp = '0;
  logic [31:0] ref_mem [logic [13:0]];
  logic [31:0] ram_m [logic [13:0]];

  mem_responder #(
    .INT_ADDR_BITS (14),
    .EXT_TIMEOUT   (TMO),
    .ERR_DATA      (ERR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .we        (we),
    .address   (address),
    .data      (data),
    .q         (q),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // Block RAM stand-in, one cycle read latency.
  always @(posedge clk) begin
    ram_q <= ram_m.exists(ram_addr) ? ram_m[ram_addr] : 32'h0;
    if (ram_we) ram_m[ram_addr] = ram_d;
  end

  // One request: cycle 0 is the cycle start is first seen.
  // ack_at: EXT_WAIT cycle (1-based) carrying ext_ack; > TMO means none.
  task automatic run_txn(
    input bit          w,
    input logic [26:0] a,
    input logic [31:0] d,
    input int          ack_at,
    input logic [31:0] rd,
    input int          hold
  );
    bit          ext;
    bit          err;
    int          done_c;
    logic [31:0] q_new;
    logic [13:0] idx;
    bit          e_busy;
    bit          e_req;
    bit          e_rwe;
    bit          e_err;
    ext = (a[26:24] != 3'b000);
    idx = a[13:0];
    q_new = q_exp;
    err = 1'b0;
    if (!ext) begin
      done_c = w ? 2 : 3;
      if (w) ref_mem[idx] = d;
      else q_new = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    end else if (ack_at <= TMO) begin
      done_c = ack_at + 1;
      if (!w) q_new = rd;
    end else begin
      done_c = TMO + 1;
      err = 1'b1;
      if (!w) q_new = ERR;
    end
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      start = 1'b1;
      if (c == 0) begin
        we = w;
        address = a;
        data = d;
      end else begin
        we = 1'($urandom);
        address = 27'($urandom);
        data = $urandom;
      end
      ext_ack = ext && (c == ack_at);
      ext_rdata = ext_ack ? rd : $urandom;
      #1;
      e_busy = (c < done_c);
      e_req = ext && c >= 1 && c < done_c;
      e_rwe = !ext && w && c == 1;
      e_err = err && c == done_c;
      n_cmp++;
      if (busy !== e_busy) begin
        n_fail++;
        $display("FAIL busy c=%0d got %b want %b", c, busy, e_busy);
      end
      n_cmp++;
      if (ext_req !== e_req) begin
        n_fail++;
        $display("FAIL ext_req c=%0d got %b want %b", c, ext_req, e_req);
      end
      n_cmp++;
      if (ram_we !== e_rwe) begin
        n_fail++;
        $display("FAIL ram_we c=%0d got %b want %b", c, ram_we, e_rwe);
      end
      n_cmp++;
      if (bus_err !== e_err) begin
        n_fail++;
        $display("FAIL bus_err c=%0d got %b want %b", c, bus_err, e_err);
      end
      if (e_req) begin
        n_cmp++;
        if (ext_addr !== a || ext_we !== w || ext_wdata !== d) begin
          n_fail++;
          $display("FAIL ext_bus c=%0d got %h/%b/%h want %h/%b/%h",
                   c, ext_addr, ext_we, ext_wdata, a, w, d);
        end
      end
      if (!ext && c == 1) begin
        n_cmp++;
        if (ram_addr !== idx || (w && ram_d !== d)) begin
          n_fail++;
          $display("FAIL ram_port got %h/%h want %h/%h",
                   ram_addr, ram_d, idx, d);
        end
      end
      n_cmp++;
      if (c < done_c && q !== q_exp) begin
        n_fail++;
        $display("FAIL q_hold c=%0d got %h want %h", c, q, q_exp);
      end else if (c == done_c && q !== q_new) begin
        n_fail++;
        $display("FAIL q_done got %h want %h", q, q_new);
      end
    end
    q_exp = q_new;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = 1'b1;
      ext_ack = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || ram_we !== 1'b0 || ext_req !== 1'b0 ||
          bus_err !== 1'b0 || q !== q_exp) begin
        n_fail++;
        $display("FAIL held_start h=%0d got b%b w%b r%b e%b q%h want q%h",
                 h, busy, ram_we, ext_req, bus_err, q, q_exp);
      end
    end
    // Gap cycle; a stray ack here must be ignored.
    @(negedge clk);
    start = 1'b0;
    ext_ack = 1'b1;
    ext_rdata = $urandom;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || q !== q_exp) begin
      n_fail++;
      $display("FAIL gap got busy %b q %h want 0 %h", busy, q, q_exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    we = 1'b1;
    address = 27'h0000010;
    data = 32'h1234_5678;
    ext_ack = 1'b0;
    ext_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || q !== 32'h0 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out got busy %b q %h err %b want 0 0 0",
               busy, q, bus_err);
    end
    n_cmp++;
    if (ram_we !== 1'b0 || ram_addr !== '0 || ram_d !== '0 ||
        ext_req !== 1'b0 || ext_addr !== '0 || ext_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got %b %h %h %b %h %h want all 0",
               ram_we, ram_addr, ram_d, ext_req, ext_addr, ext_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset_mid_ext();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b1;
      we = 1'b0;
      address = 27'h1000004;
      #1;
      n_cmp++;
      if (ext_req !== (c >= 1)) begin
        n_fail++;
        $display("FAIL pre_abort c=%0d got %b want %b", c, ext_req, c >= 1);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (ext_req !== 1'b0 || busy !== 1'b0 || q !== 32'h0) begin
      n_fail++;
      $display("FAIL abort got req %b busy %b q %h want 0 0 0",
               ext_req, busy, q);
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_abort got busy %b err %b want 0 0", busy, bus_err);
    end
    run_txn(1'b0, 27'h1000004, 32'h0, 3, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_int_write_read();
    run_txn(1'b1, 27'h0000010, 32'hCAFE_BABE, 0, 32'h0, 0);
    run_txn(1'b0, 27'h0000010, 32'h0, 0, 32'h0, 0);
    // Aliased index above 2^14 must hit the same word.
    run_txn(1'b0, 27'h0004010, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic test_ext_read();
    run_txn(1'b0, 27'h1000004, $urandom, 5, 32'h1234_5678, 0);
    run_txn(1'b1, 27'h1000008, 32'h5555_AAAA, 2, 32'h9999_9999, 0);
  endtask

  task automatic test_ext_timeout();
    run_txn(1'b0, 27'h2000008, 32'h0, TMO + 1, 32'h0, 0);
    run_txn(1'b1, 27'h2000010, 32'h7777_7777, TMO + 3, 32'h0, 0);
  endtask

  task automatic test_ack_at_timeout();
    run_txn(1'b0, 27'h3000000, 32'h0, TMO, 32'hA5A5_A5A5, 0);
  endtask

  task automatic test_held_start();
    run_txn(1'b1, 27'h0000020, 32'h1357_9BDF, 0, 32'h0, 10);
    run_txn(1'b0, 27'h1000020, 32'h0, 3, 32'h2468_ACE0, 10);
    run_txn(1'b0, 27'h0000020, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit          w;
      logic [26:0] a;
      w = 1'($urandom);
      if ($urandom_range(0, 1) == 1)
        a = {3'($urandom_range(1, 7)), 24'($urandom)};
      else
        a = {3'b000, 10'($urandom), 14'($urandom_range(0, 15))};
      run_txn(w, a, $urandom, $urandom_range(1, TMO + 2), $urandom,
              $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_ext();
    test_int_write_read();
    test_ext_read();
    test_ext_timeout();
    test_ack_at_timeout();
    test_held_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the CPU memory request interface (start/we/address/data in, q/busy out).
- Accepts one request at a time and decodes the word address into the internal block-RAM region or the external bus region.
- Sequences the target access, holds `busy` until the result is ready, then presents `q`.
- Sits between the CPU control path and the on-chip RAM / external peripheral bus.

Parameters:
- INT_ADDR_BITS, 14, width of internal RAM word index; internal region is address[26:24]==3'b000, index = address[INT_ADDR_BITS-1:0].
- EXT_TIMEOUT, 255, max cycles waiting for ext_ack before abort (1..65535).
- ERR_DATA, 32'hFFFFFFFF, value returned in q on external read timeout.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request valid, level; held by the CPU until it sees completion.
- we  in  1  1=write, 0=read; sampled with start.
- address  in  27  word address; sampled with start.
- data  in  32  write data; sampled with start.
- q  out  32  read result, registered; valid in DONE and held until next read completes.
- busy  out  1  request in progress.
- ram_addr  out  INT_ADDR_BITS  internal RAM index.
- ram_d  out  32  internal RAM write data.
- ram_we  out  1  internal RAM write strobe, one cycle.
- ram_q  in  32  internal RAM read data, 1-cycle synchronous latency.
- ext_req  out  1  external request, held until ack or timeout.
- ext_we  out  1  external write.
- ext_addr  out  27  external address.
- ext_wdata  out  32  external write data.
- ext_ack  in  1  external completion, single-cycle pulse.
- ext_rdata  in  32  external read data, valid with ext_ack.
- bus_err  out  1  one-cycle pulse on external timeout.

Behaviour:
- Reset, asynchronous and active-low:
  - State goes to IDLE.
  - q, ram_*, ext_*, bus_err, latched request and timeout counter all go to 0.
  - busy is forced to 0 while reset is low.
  - Reset mid-transaction aborts it immediately; ext_req drops asynchronously and no q update occurs.
- States: IDLE, INT_ACC, INT_RD, EXT_WAIT, DONE.
- IDLE:
  - On start=1: latch we/address/data.
  - Next state is INT_ACC if address[26:24]==0, else EXT_WAIT.
- INT_ACC:
  - Drive ram_addr from the latched address and ram_d from the latched data.
  - Write: ram_we=1 this cycle only, next state DONE.
  - Read: next state INT_RD.
- INT_RD: q<=ram_q, next state DONE.
- EXT_WAIT:
  - ext_req=1, with ext_we/ext_addr/ext_wdata from the latched request, stable throughout.
  - Timeout counter starts at 0 on entry and increments each cycle without ack.
  - ext_ack=1: if read, q<=ext_rdata; next state DONE; ext_req is 0 in the following cycle.
  - Counter==EXT_TIMEOUT-1 without ack: bus_err pulses the next cycle; if read, q<=ERR_DATA; next state DONE.
  - ext_ack in the same cycle as the timeout is treated as ack: no error, data taken.
- busy is combinational: (state==IDLE && start) || state in {INT_ACC, INT_RD, EXT_WAIT}.
  - busy rises in the same cycle start is first seen.
  - busy is 0 in DONE.
- DONE:
  - busy=0, q valid.
  - Remain in DONE while start=1, so a held start is never re-accepted.
  - Return to IDLE when start=0. A new request needs start low for at least one cycle.
- Latency, start-seen cycle = 0:
  - Internal write: busy high for cycles 0-1, DONE at cycle 2.
  - Internal read: busy high for cycles 0-2, DONE at cycle 3.
  - External access: DONE one cycle after ack.
- Writes never modify q.
- Internal region addresses above 2^INT_ADDR_BITS alias (upper bits ignored).
- ext_ack outside EXT_WAIT is ignored.
- we/address/data changes after acceptance are ignored.

Decomposition:
- Shared package:
  - State enum encoding.
  - REGION_INT = 3'b000.
  - Defaults for EXT_TIMEOUT and ERR_DATA.
- One sub-module: mem_ext_timer.
  - Inputs: clear, enable, limit.
  - Output: expired.
  - Used by the responder for the EXT_WAIT timeout.

Test Plan:
- Internal write then read: write address 0x0000010, data 0xCAFEBABE, start held 2 cycles.
  - ram_we pulses once at cycle 1; busy drops at cycle 2.
  - After start low, a read of 0x10 returns q=0xCAFEBABE at cycle 3.
- External read: address 0x1000004; ack after 5 cycles with ext_rdata=0x12345678.
  - ext_req high for 5 cycles with ext_addr=0x1000004.
  - q=0x12345678 and busy=0 the cycle after ack; bus_err stays 0.
- External timeout: EXT_TIMEOUT=8, no ack.
  - ext_req high for 8 cycles, then bus_err=1 for one cycle.
  - q=0xFFFFFFFF, busy=0.
- Ack coincident with timeout: ack in the 8th EXT_WAIT cycle with rdata 0xA5A5A5A5.
  - q=0xA5A5A5A5, no bus_err.
- Held start: start kept high 10 cycles after DONE.
  - No second ram_we/ext_req; busy stays 0.
  - Drop start 1 cycle then re-raise: a new transaction starts.
- Reset mid EXT_WAIT: reset low in cycle 3.
  - ext_req=0 and busy=0 immediately; q unchanged at 0.
  - After release, state is IDLE and a new request completes normally.
